// File: rtl/midi_pkg.sv
// Shared MIDI constants, byte classes, parser FSM encoding and the
// status-to-data-length lookup used by the message parser.
package midi_pkg;

  localparam logic [7:0] NOTE_OFF    = 8'h80;
  localparam logic [7:0] NOTE_ON     = 8'h90;
  localparam logic [7:0] POLY_AT     = 8'hA0;
  localparam logic [7:0] CTRL_CHG    = 8'hB0;
  localparam logic [7:0] PROG_CHG    = 8'hC0;
  localparam logic [7:0] CHAN_AT     = 8'hD0;
  localparam logic [7:0] PITCH_BEND  = 8'hE0;
  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] MTC_QF      = 8'hF1;
  localparam logic [7:0] SONG_POS    = 8'hF2;
  localparam logic [7:0] SONG_SEL    = 8'hF3;
  localparam logic [7:0] UNDEF_F4    = 8'hF4;
  localparam logic [7:0] UNDEF_F5    = 8'hF5;
  localparam logic [7:0] TUNE_REQ    = 8'hF6;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  localparam logic [1:0] LEN_INVALID = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_CAP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_DATA   = 2'd0,
    CLS_CHAN   = 2'd1,
    CLS_SYSCOM = 2'd2,
    CLS_RT     = 2'd3
  } byte_class_t;

  // Data bytes and bytes that never carry data (F0, F4, F5, F7) map to LEN_INVALID.
  function automatic logic [1:0] status_len(input logic [7:0] code);
    logic [1:0] len;
    len = LEN_INVALID;
    if (code[7] == 1'b0) begin
      len = LEN_INVALID;
    end else if (code < SYSEX_START) begin
      case (code[7:4])
        PROG_CHG[7:4], CHAN_AT[7:4]: len = 2'd1;
        default:                     len = 2'd2;
      endcase
    end else begin
      case (code)
        MTC_QF, SONG_SEL:                          len = 2'd1;
        SONG_POS:                                  len = 2'd2;
        TUNE_REQ:                                  len = 2'd0;
        SYSEX_START, UNDEF_F4, UNDEF_F5, SYSEX_END: len = LEN_INVALID;
        default:                                   len = 2'd0;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/midi_len_decode.sv
// Combinational byte classifier: data / channel status / system common /
// real-time, plus the expected data-byte count for status bytes.
module midi_len_decode
  import midi_pkg::*;
(
  input  logic [7:0]  code,
  output byte_class_t cls,
  output logic [1:0]  len
);

  // Classify the byte and look up its data length.
  always_comb begin
    len = status_len(code);
    if (code[7] == 1'b0) begin
      cls = CLS_DATA;
    end else if (code >= RT_MIN) begin
      cls = CLS_RT;
    end else if (code >= SYSEX_START) begin
      cls = CLS_SYSCOM;
    end else begin
      cls = CLS_CHAN;
    end
  end

endmodule

// File: rtl/midi_msg_parser.sv
// Drains the MIDI receive FIFO one byte per three cycles and assembles
// complete messages (running status, real-time, SysEx discard) for the router.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_rdy,
  output logic             in_rd,
  output logic [7:0]       msg_status,
  output logic [7:0]       msg_data1,
  output logic [7:0]       msg_data2,
  output logic [1:0]       msg_len,
  output logic             msg_valid,
  input  logic             msg_ack,
  output logic [ERR_W-1:0] err_cnt
);

  state_t      state_r;
  logic [7:0]  cur_status_r;
  logic        have_status_r;
  logic        running_r;
  logic [1:0]  exp_len_r;
  logic        idx_r;
  logic [7:0]  data1_r;
  logic        sysex_r;

  byte_class_t cls_s;
  logic [1:0]  len_s;
  logic        err_bump_s;

  midi_len_decode u_dec (
    .code (in_data),
    .cls  (cls_s),
    .len  (len_s)
  );

  // Protocol error detection for the byte being captured.
  always_comb begin
    err_bump_s = 1'b0;
    if (state_r == S_CAP) begin
      case (cls_s)
        CLS_DATA:            err_bump_s = ~sysex_r & ~have_status_r;
        CLS_CHAN, CLS_SYSCOM: err_bump_s = idx_r;
        default:             err_bump_s = 1'b0;
      endcase
    end else begin
      err_bump_s = 1'b0;
    end
  end

  // Main FSM: read strobe, byte capture, message assembly and handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= S_IDLE;
      in_rd         <= 1'b0;
      msg_status    <= 8'h00;
      msg_data1     <= 8'h00;
      msg_data2     <= 8'h00;
      msg_len       <= 2'd0;
      msg_valid     <= 1'b0;
      err_cnt       <= '0;
      cur_status_r  <= 8'h00;
      have_status_r <= 1'b0;
      running_r     <= 1'b0;
      exp_len_r     <= 2'd0;
      idx_r         <= 1'b0;
      data1_r       <= 8'h00;
      sysex_r       <= 1'b0;
    end else begin
      if (msg_valid && msg_ack) begin
        msg_valid <= 1'b0;
      end

      if (err_bump_s && (err_cnt != {ERR_W{1'b1}})) begin
        err_cnt <= err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
      end

      case (state_r)
        S_IDLE: begin
          in_rd <= 1'b0;
          // The ack cycle already frees the output register for the next byte.
          if (in_rdy && (!msg_valid || msg_ack)) begin
            state_r <= S_REQ;
            in_rd   <= 1'b1;
          end
        end

        S_REQ: begin
          in_rd   <= 1'b0;
          state_r <= S_CAP;
        end

        S_CAP: begin
          in_rd   <= 1'b0;
          state_r <= S_IDLE;
          case (cls_s)
            CLS_RT: begin
              msg_status <= in_data;
              msg_data1  <= 8'h00;
              msg_data2  <= 8'h00;
              msg_len    <= 2'd0;
              msg_valid  <= 1'b1;
            end

            CLS_DATA: begin
              if (sysex_r || !have_status_r) begin
                idx_r <= 1'b0;
              end else if (!idx_r) begin
                data1_r <= in_data;
                if (exp_len_r == 2'd1) begin
                  msg_status    <= cur_status_r;
                  msg_data1     <= in_data;
                  msg_data2     <= 8'h00;
                  msg_len       <= 2'd1;
                  msg_valid     <= 1'b1;
                  have_status_r <= running_r;
                end else begin
                  idx_r <= 1'b1;
                end
              end else begin
                msg_status    <= cur_status_r;
                msg_data1     <= data1_r;
                msg_data2     <= in_data;
                msg_len       <= 2'd2;
                msg_valid     <= 1'b1;
                idx_r         <= 1'b0;
                have_status_r <= running_r;
              end
            end

            CLS_CHAN: begin
              idx_r         <= 1'b0;
              sysex_r       <= 1'b0;
              cur_status_r  <= in_data;
              exp_len_r     <= len_s;
              have_status_r <= 1'b1;
              running_r     <= 1'b1;
            end

            CLS_SYSCOM: begin
              idx_r <= 1'b0;
              case (in_data)
                SYSEX_START: begin
                  sysex_r       <= 1'b1;
                  have_status_r <= 1'b0;
                end
                // F7 only closes SysEx; running status survives a stray F7.
                SYSEX_END: begin
                  sysex_r <= 1'b0;
                end
                TUNE_REQ: begin
                  sysex_r       <= 1'b0;
                  have_status_r <= 1'b0;
                  msg_status    <= in_data;
                  msg_data1     <= 8'h00;
                  msg_data2     <= 8'h00;
                  msg_len       <= 2'd0;
                  msg_valid     <= 1'b1;
                end
                MTC_QF, SONG_POS, SONG_SEL: begin
                  sysex_r       <= 1'b0;
                  cur_status_r  <= in_data;
                  exp_len_r     <= len_s;
                  have_status_r <= 1'b1;
                  running_r     <= 1'b0;
                end
                default: begin
                  sysex_r       <= 1'b0;
                  have_status_r <= 1'b0;
                end
              endcase
            end

            default: begin
              idx_r <= 1'b0;
            end
          endcase
        end

        default: begin
          in_rd   <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
